// File: rtl/pattern_hit_logger.sv
// Hit logger behind pattern_detect: re-trigger holdoff, timestamping, FWFT queue of
// {mask, ts} with valid/ready readout, and saturating hit/drop statistics.
module pattern_hit_logger #(
    parameter int MASK_W     = 10,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLDOFF    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          detected,
    input  logic [MASK_W-1:0]             detected_mask,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MASK_W-1:0]             out_mask,
    output logic [TS_W-1:0]               out_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic                          overflow
);
    // state | meaning
    // IDLE  | armed, an ena cycle with detected accepts a hit
    // HOLD  | re-trigger holdoff running, detected ignored
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int EW = MASK_W + TS_W;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [TS_W-1:0] ts;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;

    logic accept;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign accept    = ena & detected & (state == IDLE);
    assign out_valid = (cnt != '0);
    assign full      = (cnt == CW'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = accept & (~full | pop);
    assign drop      = accept & ~push;

    assign out_mask  = out_valid ? mem[rd_ptr][EW-1:TS_W] : '0;
    assign out_ts    = out_valid ? mem[rd_ptr][TS_W-1:0]  : '0;
    assign fifo_cnt  = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ts       <= '0;
        end else if (ena) begin
            ts <= ts + TS_W'(1);
            case (state)
                IDLE: begin
                    if (detected && HOLDOFF > 0) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(HOLDOFF);
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - HW'(1);
                    if (hold_cnt == HW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; contents are only visible through cnt.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {detected_mask, ts};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    // clear wins over a coincident increment; the hit itself still reaches the FIFO.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hit_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_hit_logger.sv
// Directed bench for pattern_hit_logger: vector table plus hand sequences for
// holdoff, overflow, full push/pop, ena freeze, clear and reset.
module tb_pattern_hit_logger;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        detected;
    logic [9:0]  detected_mask;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  out_mask;
    logic [15:0] out_ts;
    logic [3:0]  fifo_cnt;
    logic [15:0] hit_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    // Small-counter, no-holdoff, 2-deep instance to reach saturation quickly.
    logic        s_valid;
    logic [9:0]  s_mask;
    logic [15:0] s_ts;
    logic [1:0]  s_fcnt;
    logic [2:0]  s_hit;
    logic [2:0]  s_drop;
    logic        s_ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int tb_ts  = 0;

    always #5 clk = ~clk;

    pattern_hit_logger dut (
        .clk(clk), .rst(rst), .ena(ena), .detected(detected),
        .detected_mask(detected_mask), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_mask(out_mask), .out_ts(out_ts),
        .fifo_cnt(fifo_cnt), .hit_cnt(hit_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    pattern_hit_logger #(.CNT_W(3), .HOLDOFF(0), .FIFO_DEPTH(2)) dut_s (
        .clk(clk), .rst(rst), .ena(ena), .detected(detected),
        .detected_mask(detected_mask), .clear(clear), .out_valid(s_valid),
        .out_ready(out_ready), .out_mask(s_mask), .out_ts(s_ts),
        .fifo_cnt(s_fcnt), .hit_cnt(s_hit), .drop_cnt(s_drop),
        .overflow(s_ovf)
    );

    typedef struct packed {
        logic        rst_first;
        logic [15:0] at_ts;
        logic        ena;
        logic        det;
        logic [9:0]  mask;
        logic        rdy;
        logic        clr;
        logic        e_v;
        logic [9:0]  e_m;
        logic [15:0] e_ts;
        logic [3:0]  e_f;
        logic [15:0] e_h;
        logic [15:0] e_d;
        logic        e_o;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic r, int at, logic en, logic d, logic [9:0] m,
                                logic rd, logic cl, logic ev, logic [9:0] em,
                                int ets, int ef, int eh, int ed, logic eo);
        vec_t v;
        v.rst_first = r;  v.at_ts = 16'(at); v.ena = en; v.det = d; v.mask = m;
        v.rdy = rd; v.clr = cl; v.e_v = ev; v.e_m = em; v.e_ts = 16'(ets);
        v.e_f = 4'(ef); v.e_h = 16'(eh); v.e_d = 16'(ed); v.e_o = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (tb_ts=%0d)", nm, act, exp, tb_ts);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) tb_ts = 0;
        else if (ena) tb_ts++;
        #2;
    endtask

    task automatic wait_ts(input int t);
        int guard = 0;
        while (tb_ts != t && guard < 1000) begin
            ena = 1'b1; detected = 1'b0; clear = 1'b0;
            tick();
            guard++;
        end
        if (tb_ts != t) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_ts: reached %0d expected %0d", tb_ts, t);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; detected = 1'b1; detected_mask = '1;
        clear = 1'b0; out_ready = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_fcnt",  32'(fifo_cnt), 0);
        chk("rst_hit",   32'(hit_cnt), 0);
        chk("rst_drop",  32'(drop_cnt), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_mask",  32'(out_mask), 0);
        chk("rst_ts",    32'(out_ts), 0);
        rst = 1'b0; detected = 1'b0; detected_mask = '0;
    endtask

    task automatic hit_at(input int t, input logic [9:0] m);
        wait_ts(t);
        detected = 1'b1; detected_mask = m;
        tick();
        detected = 1'b0;
    endtask

    initial begin
        int got[$];
        rst = 1'b0; ena = 1'b0; detected = 1'b0; detected_mask = '0;
        clear = 1'b0; out_ready = 1'b0;

        // single pulse, 1-cycle latency, pop
        vecs[0]  = mk(1, 20, 1, 1, 10'h0F3, 1, 0, 1, 10'h0F3, 20, 1, 1, 0, 0);
        vecs[1]  = mk(0, 21, 1, 0, 10'h000, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        // ena freeze: hit at 50, ena=0 x5 with detected, holdoff resumes, next hit at 55
        vecs[2]  = mk(1, 50, 1, 1, 10'h155, 1, 0, 1, 10'h155, 50, 1, 1, 0, 0);
        vecs[3]  = mk(0, 51, 0, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 51, 0, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 51, 0, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 51, 0, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[7]  = mk(0, 51, 0, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[8]  = mk(0, 51, 1, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[9]  = mk(0, 52, 1, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[10] = mk(0, 53, 1, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[11] = mk(0, 54, 1, 1, 10'h3FF, 1, 0, 0, 10'h000,  0, 0, 1, 0, 0);
        vecs[12] = mk(0, 55, 1, 1, 10'h0AB, 1, 0, 1, 10'h0AB, 55, 1, 2, 0, 0);
        vecs[13] = mk(0, 56, 1, 0, 10'h000, 1, 0, 0, 10'h000,  0, 0, 2, 0, 0);
        // clear coincident with a hit at 30
        vecs[14] = mk(1, 24, 1, 1, 10'h003, 0, 0, 1, 10'h003, 24, 1, 1, 0, 0);
        vecs[15] = mk(0, 30, 1, 1, 10'h2AA, 0, 1, 1, 10'h003, 24, 2, 0, 0, 0);
        vecs[16] = mk(0, 31, 1, 0, 10'h000, 1, 0, 1, 10'h2AA, 30, 1, 0, 0, 0);
        vecs[17] = mk(0, 32, 1, 0, 10'h000, 1, 0, 0, 10'h000,  0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst_first) do_reset();
            out_ready = vecs[i].rdy;
            wait_ts(int'(vecs[i].at_ts));
            ena = vecs[i].ena; detected = vecs[i].det; detected_mask = vecs[i].mask;
            clear = vecs[i].clr; out_ready = vecs[i].rdy;
            tick();
            detected = 1'b0; clear = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_v));
            chk($sformatf("v%0d_mask", i),  32'(out_mask),  32'(vecs[i].e_m));
            chk($sformatf("v%0d_ts", i),    32'(out_ts),    32'(vecs[i].e_ts));
            chk($sformatf("v%0d_fcnt", i),  32'(fifo_cnt),  32'(vecs[i].e_f));
            chk($sformatf("v%0d_hit", i),   32'(hit_cnt),   32'(vecs[i].e_h));
            chk($sformatf("v%0d_drop", i),  32'(drop_cnt),  32'(vecs[i].e_d));
            chk($sformatf("v%0d_ovf", i),   32'(overflow),  32'(vecs[i].e_o));
        end

        // holdoff: detected high 12 cycles from ts=100
        do_reset();
        out_ready = 1'b1;
        wait_ts(100);
        detected_mask = 10'h021;
        for (int i = 0; i < 14; i++) begin
            detected = (i < 12);
            tick();
            if (out_valid) got.push_back(int'(out_ts));
        end
        detected = 1'b0;
        chk("hold_entries", 32'(got.size()), 3);
        for (int k = 0; k < 3; k++)
            if (k < got.size()) chk($sformatf("hold_ts%0d", k), 32'(got[k]), 32'(100 + 5 * k));
        chk("hold_hit",  32'(hit_cnt), 3);
        chk("hold_drop", 32'(drop_cnt), 0);
        chk("s_hit_sat", 32'(s_hit), 7);
        chk("s_drop0",   32'(s_drop), 0);

        // overflow: 12 hits with out_ready=0, then drain
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) hit_at(200 + 10 * k, 10'(k + 1));
        chk("ovf_fcnt", 32'(fifo_cnt), 8);
        chk("ovf_drop", 32'(drop_cnt), 4);
        chk("ovf_ovf",  32'(overflow), 1);
        chk("ovf_hit",  32'(hit_cnt), 12);
        chk("s_hit",    32'(s_hit), 7);
        chk("s_drop",   32'(s_drop), 7);
        chk("s_ovf",    32'(s_ovf), 1);
        chk("s_fcnt",   32'(s_fcnt), 2);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_valid%0d", k), 32'(out_valid), 1);
            chk($sformatf("drain_ts%0d", k),    32'(out_ts), 32'(200 + 10 * k));
            chk($sformatf("drain_mask%0d", k),  32'(out_mask), 32'(k + 1));
            tick();
        end
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_mask0", 32'(out_mask), 0);
        chk("drain_fcnt",  32'(fifo_cnt), 0);

        // full FIFO with push and pop in the same cycle
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) hit_at(300 + 10 * k, 10'h100);
        chk("full_fcnt", 32'(fifo_cnt), 8);
        wait_ts(400);
        detected = 1'b1; detected_mask = 10'h3C3; out_ready = 1'b1;
        tick();
        detected = 1'b0; out_ready = 1'b0;
        chk("pp_fcnt", 32'(fifo_cnt), 8);
        chk("pp_drop", 32'(drop_cnt), 0);
        chk("pp_ovf",  32'(overflow), 0);
        chk("pp_head", 32'(out_ts), 310);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pp_ts%0d", k), 32'(out_ts), (k < 7) ? 32'(310 + 10 * k) : 32'd400);
            tick();
        end
        chk("pp_empty", 32'(out_valid), 0);

        // reset with three entries queued discards them and zeroes ts
        do_reset();
        out_ready = 1'b0;
        hit_at(10, 10'h001); hit_at(15, 10'h002); hit_at(20, 10'h004);
        chk("q3_fcnt", 32'(fifo_cnt), 3);
        do_reset();
        detected = 1'b1; detected_mask = 10'h111; out_ready = 1'b0;
        tick();
        detected = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_ts",    32'(out_ts), 0);
        chk("post_rst_mask",  32'(out_mask), 32'h111);
        chk("post_rst_fcnt",  32'(fifo_cnt), 1);
        chk("post_rst_hit",   32'(hit_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
